// File: rtl/uart_rx_param_pkg.sv
// Shared types and defaults for the parametrised UART receiver.
// State and parity encodings plus the 3-sample majority helper.
package uart_rx_param_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_BITS    = 1;

  typedef enum logic [2:0] {
    RX2_IDLE   = 3'd0,
    RX2_START  = 3'd1,
    RX2_DATA   = 3'd2,
    RX2_PARITY = 3'd3,
    RX2_STOP   = 3'd4
  } rx2_state;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser and 3-sample majority vote, 2-cycle latency.
// No backpressure; samples every cycle.
module uart_rx_sampler
  import uart_rx_param_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_majority
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;

  always_comb begin
    sync1_d = i_line;
    sync2_d = sync1_q;
    hist_d  = {hist_q[0], sync2_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // The newest vote sample is the synchroniser output itself.
  assign o_sync     = sync2_q;
  assign o_majority = majority3({hist_q, sync2_q});

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with parity/stop checking; o_valid_rx rises 3 cycles after the last stop sample.
// One-entry holding register with valid/ready; a frame finishing while it is full is dropped and flags overrun.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = DEF_STOP_BITS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data_rx,
  input  logic                 i_enb_rx,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_ready_rx,
  input  logic                 i_clr_ovr,
  output logic [DATA_BITS-1:0] o_data_rx,
  output logic                 o_valid_rx,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = RX2_IDLE;
  localparam logic [2:0] S_START  = RX2_START;
  localparam logic [2:0] S_DATA   = RX2_DATA;
  localparam logic [2:0] S_PARITY = RX2_PARITY;
  localparam logic [2:0] S_STOP   = RX2_STOP;

  logic line_sync, maj;

  uart_rx_sampler u_sampler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_line     (i_data_rx),
    .o_sync     (line_sync),
    .o_majority (maj)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           mode_q, mode_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 complete, ferr_fin, par_on, bit_done;

  always_comb begin
    state_d    = state_q;
    tick_d     = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    armed_d    = armed_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;
    bit_done   = (tick_q == TICK_LAST);
    ferr_fin   = ferr_q | ~maj;
    par_on     = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        // A held-low line must go high once before a new start is accepted.
        if (line_sync) armed_d = 1'b1;
        if (i_enb_rx && armed_q && !line_sync) begin
          state_d = S_START;
          mode_d  = i_parity_mode;
          armed_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_q == TICK_MID) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            tick_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = par_on ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          perr_d  = (^shift_q) ^ maj ^ (mode_q == PAR_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          ferr_d = ferr_fin;
          bit_d  = bit_q + 4'd1;
          if (bit_q == STOP_LAST) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !i_enb_rx) begin
      state_d  = S_IDLE;
      complete = 1'b0;
    end

    if (complete && (!valid_q || i_ready_rx)) begin
      data_d     = shift_q;
      perr_out_d = perr_q;
      ferr_out_d = ferr_fin;
      valid_d    = 1'b1;
    end else if (valid_q && i_ready_rx) begin
      valid_d = 1'b0;
    end

    if (i_clr_ovr) ovr_d = 1'b0;
    if (complete && valid_q && !i_ready_rx) ovr_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      mode_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data_rx    = data_q;
  assign o_valid_rx   = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus random frames against a frame-level model.
// Two instances: 1 stop bit (main) and 2 stop bits (line2, ready held low).
module tb_uart_rx_param;

  localparam int C   = 16;
  localparam int MID = C / 2;

  logic       clk = 1'b0;
  logic       rst_n, line, line2, enb, ready, rdy2, clr;
  logic [1:0] mode;
  logic [7:0] data1, data2;
  logic       vld1, vld2, pe1, pe2, fe1, fe2, ov1, ov2;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_rx(line), .i_enb_rx(enb),
    .i_parity_mode(mode), .i_ready_rx(ready), .i_clr_ovr(clr),
    .o_data_rx(data1), .o_valid_rx(vld1), .o_parity_err(pe1),
    .o_frame_err(fe1), .o_overrun(ov1)
  );

  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(C)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_rx(line2), .i_enb_rx(enb),
    .i_parity_mode(mode), .i_ready_rx(rdy2), .i_clr_ovr(clr),
    .o_data_rx(data2), .o_valid_rx(vld2), .o_parity_err(pe2),
    .o_frame_err(fe2), .o_overrun(ov2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records every rising edge of o_valid_rx with the word it presents, and high-time widths.
  int         rise_cyc_q[$];
  logic [7:0] rise_dat_q[$];
  logic       rise_pe_q[$];
  logic       rise_fe_q[$];
  int         width_q[$];
  int         last_rise = 0;
  logic       v_prev = 1'b0;

  always @(negedge clk) begin
    if (vld1 && !v_prev) begin
      rise_cyc_q.push_back(cyc);
      rise_dat_q.push_back(data1);
      rise_pe_q.push_back(pe1);
      rise_fe_q.push_back(fe1);
      last_rise = cyc;
    end
    if (!vld1 && v_prev) width_q.push_back(cyc - last_rise);
    v_prev = vld1;
  end

  task automatic flush();
    rise_cyc_q.delete();
    rise_dat_q.delete();
    rise_pe_q.delete();
    rise_fe_q.delete();
    width_q.delete();
  endtask

  bit fbits[$];
  int start_cyc = 0;

  task automatic build(input logic [7:0] d, input int pm, input logic p,
                       input logic s1, input logic s2, input int nstop);
    mode = 2'(pm);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) fbits.push_back(d[i]);
    if (pm == 1 || pm == 2) fbits.push_back(p);
    fbits.push_back(s1);
    if (nstop == 2) fbits.push_back(s2);
  endtask

  // Drives nb bits (all when nb<0) of fbits, C cycles each; optional 1-cycle inverted spike at mid-bit.
  task automatic drive(input bit to2, input int spike, input int nb);
    int n = (nb < 0) ? fbits.size() : nb;
    bit v;
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < C; j++) begin
        @(posedge clk); #1;
        if (b == 0 && j == 0) start_cyc = cyc;
        if (b == 2 && j == 0) mode = 2'($urandom_range(0, 3));
        v = fbits[b] ^ (b == spike && j == MID);
        if (to2) line2 = v;
        else line = v;
      end
    end
  endtask

  function automatic logic model_perr(input logic [7:0] d, input int pm, input logic p);
    int ones = $countones(d) + int'(p);
    if (pm != 1 && pm != 2) return 1'b0;
    return (ones % 2) != ((pm == 2) ? 1 : 0);
  endfunction

  function automatic int exp_rise(input int sc, input int len);
    return sc + 4 + MID + (len - 1) * C;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input int pm, input logic p,
                           input logic s, input int spike);
    int er;
    flush();
    build(d, pm, p, s, 1'b1, 1);
    drive(1'b0, spike, -1);
    line = 1'b1;
    er = exp_rise(start_cyc, fbits.size());
    idle(2 * C);
    chk("nvalid", 32'(rise_cyc_q.size()), 32'd1);
    if (rise_cyc_q.size() > 0) begin
      chk("rise_cyc", rise_cyc_q.pop_front(), er);
      chk("data", 32'(rise_dat_q.pop_front()), 32'(d));
      chk("perr", 32'(rise_pe_q.pop_front()), 32'(model_perr(d, pm, p)));
      chk("ferr", 32'(rise_fe_q.pop_front()), 32'(!s));
    end
    chk("nfall", 32'(width_q.size()), 32'd1);
    if (width_q.size() > 0) chk("vld_width", width_q.pop_front(), 32'd1);
    chk("overrun", 32'(ov1), 32'd0);
  endtask

  // Pulses clr (which=0) or raises ready (which=1) in the completion cycle of a frame of len bits.
  task automatic at_completion(input int len, input int which);
    @(posedge clk); #1;
    repeat (4 + MID + (len - 1) * C - 1) @(posedge clk);
    #1;
    if (which == 0) clr = 1'b1;
    else ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int         rpm, rsp, sc;
    logic       rp, rs;

    rst_n = 1'b0; line = 1'b1; line2 = 1'b1; enb = 1'b1; mode = 2'd0;
    ready = 1'b1; rdy2 = 1'b0; clr = 1'b0;
    idle(3);
    chk("rst_vld", 32'(vld1), 32'd0);
    chk("rst_data", 32'(data1), 32'd0);
    chk("rst_perr", 32'(pe1), 32'd0);
    chk("rst_ferr", 32'(fe1), 32'd0);
    chk("rst_ovr", 32'(ov1), 32'd0);
    chk("rst_vld2", 32'(vld2), 32'd0);
    rst_n = 1'b1;
    idle(5);

    run_frame(8'hA5, 0, 1'b0, 1'b1, -1);
    run_frame(8'h3C, 1, 1'b1, 1'b1, -1);
    run_frame(8'h3C, 1, 1'b0, 1'b1, -1);
    run_frame(8'h3C, 2, 1'b1, 1'b1, -1);
    run_frame(8'h55, 0, 1'b0, 1'b0, -1);
    run_frame(8'h5A, 3, 1'b0, 1'b1, 4);

    build(8'h69, 0, 1'b0, 1'b1, 1'b1, 2);
    drive(1'b1, -1, -1);
    line2 = 1'b1;
    idle(2 * C);
    chk("s2_vld_a", 32'(vld2), 32'd1);
    chk("s2_data_a", 32'(data2), 32'h69);
    chk("s2_ferr_a", 32'(fe2), 32'd0);
    rdy2 = 1'b1;
    idle(1);
    rdy2 = 1'b0;
    build(8'h96, 0, 1'b0, 1'b1, 1'b0, 2);
    drive(1'b1, -1, -1);
    line2 = 1'b1;
    idle(2 * C);
    chk("s2_vld_b", 32'(vld2), 32'd1);
    chk("s2_data_b", 32'(data2), 32'h96);
    chk("s2_ferr_b", 32'(fe2), 32'd1);
    chk("s2_perr_b", 32'(pe2), 32'd0);
    chk("s2_ovr", 32'(ov2), 32'd0);

    flush();
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(3 * C);
    chk("glitch_nvalid", 32'(rise_cyc_q.size()), 32'd0);
    run_frame(8'h12, 0, 1'b0, 1'b1, -1);

    ready = 1'b0;
    build(8'h11, 0, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, -1, -1);
    line = 1'b1;
    idle(2 * C);
    chk("ovr_vld1", 32'(vld1), 32'd1);
    chk("ovr_data1", 32'(data1), 32'h11);
    chk("ovr_flag1", 32'(ov1), 32'd0);
    build(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, -1, -1);
    line = 1'b1;
    idle(2 * C);
    chk("ovr_vld2", 32'(vld1), 32'd1);
    chk("ovr_data2", 32'(data1), 32'h11);
    chk("ovr_flag2", 32'(ov1), 32'd1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("ovr_clr", 32'(ov1), 32'd0);
    build(8'h33, 0, 1'b0, 1'b1, 1'b1, 1);
    fork
      drive(1'b0, -1, -1);
      at_completion(10, 0);
    join
    line = 1'b1;
    idle(2 * C);
    chk("ovr_setwins", 32'(ov1), 32'd1);
    chk("ovr_data3", 32'(data1), 32'h11);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("ovr_clr2", 32'(ov1), 32'd0);
    build(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
    fork
      drive(1'b0, -1, -1);
      at_completion(10, 1);
    join
    line = 1'b1;
    idle(2 * C);
    chk("rdy_data", 32'(data1), 32'h22);
    chk("rdy_ovr", 32'(ov1), 32'd0);
    chk("rdy_vld", 32'(vld1), 32'd0);

    build(8'hC3, 0, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, -1, 4);
    rst_n = 1'b0;
    line = 1'b1;
    idle(2);
    chk("mrst_vld", 32'(vld1), 32'd0);
    chk("mrst_data", 32'(data1), 32'd0);
    chk("mrst_perr", 32'(pe1), 32'd0);
    chk("mrst_ferr", 32'(fe1), 32'd0);
    chk("mrst_ovr", 32'(ov1), 32'd0);
    rst_n = 1'b1;
    idle(4);
    run_frame(8'hF0, 0, 1'b0, 1'b1, -1);

    flush();
    build(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b0, -1, 5);
    line = 1'b1;
    enb = 1'b0;
    idle(2);
    enb = 1'b1;
    idle(3 * C);
    chk("enb_nvalid", 32'(rise_cyc_q.size()), 32'd0);
    chk("enb_data", 32'(data1), 32'hF0);
    chk("enb_vld", 32'(vld1), 32'd0);
    run_frame(8'hF0, 0, 1'b0, 1'b1, -1);

    flush();
    mode = 2'd0;
    @(posedge clk); #1;
    sc = cyc;
    line = 1'b0;
    idle(13 * C);
    chk("brk_nvalid", 32'(rise_cyc_q.size()), 32'd1);
    if (rise_cyc_q.size() > 0) begin
      chk("brk_rise", rise_cyc_q.pop_front(), exp_rise(sc, 10));
      chk("brk_data", 32'(rise_dat_q.pop_front()), 32'd0);
      chk("brk_ferr", 32'(rise_fe_q.pop_front()), 32'd1);
    end
    line = 1'b1;
    idle(2 * C);
    run_frame(8'h81, 0, 1'b0, 1'b1, -1);

    for (int k = 0; k < 40; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rpm = int'($urandom_range(0, 3));
      rp  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 3) != 0);
      rsp = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 10)) : -1;
      run_frame(rd, rpm, rp, rs, rsp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the board's serial RX path.
- Adds over the current receiver: configurable data width, runtime-selectable parity, 1 or 2 stop bits, glitch-rejecting start detection and 3-sample majority voting.
- Adds parity, framing and overrun error reporting, and a valid/ready output handshake with a one-entry holding register.
- Sits between the FPGA RX pin and the LED/command consumer logic.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9.
- STOP_BITS, 1: stop bits, legal 1 or 2.
- CLKS_PER_BIT, 434: i_clk cycles per bit period (50 MHz / 115200), minimum 8.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data_rx  in  1  raw serial line, idle high, asynchronous to i_clk.
- i_enb_rx  in  1  receiver enable.
- i_parity_mode  in  2  0=none, 1=even, 2=odd, 3=none.
- i_ready_rx  in  1  consumer accepts the held word.
- i_clr_ovr  in  1  clears o_overrun (one-cycle pulse).
- o_data_rx  out  DATA_BITS  received word, LSB = first bit on the line.
- o_valid_rx  out  1  held word valid.
- o_parity_err  out  1  parity error for the held word.
- o_frame_err  out  1  stop-bit error for the held word.
- o_overrun  out  1  sticky: a frame was dropped because the holding register was full.

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, all outputs 0, both synchroniser flops 1.
- Line path: 2-flop synchroniser, then 3-deep sample shift register; the majority of the 3 samples is "bit value".
- MID = CLKS_PER_BIT/2. tick_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0; bit_cnt counts data and stop bits.
- IDLE: clear tick_cnt and bit_cnt. Go to START when i_enb_rx=1 and the synchronised line is 0. Latch i_parity_mode at that moment; mode changes mid-frame are ignored.
- START: at tick_cnt==MID, evaluate the majority.
  - Majority 1: glitch; go to IDLE with no output.
  - Majority 0: go to DATA with tick_cnt reset to 0, so every later sample point falls at mid-bit.
- DATA: at tick_cnt==CLKS_PER_BIT-1, shift the majority value in from the MSB side (LSB-first reception) and increment bit_cnt. After DATA_BITS bits, go to PARITY if the latched mode is 1 or 2, otherwise go to STOP.
- PARITY: sample after one bit period. Error if XOR(data, sampled parity bit) is not 0 in even mode, or not 1 in odd mode. Then go to STOP.
- STOP: sample each stop bit after one bit period. Any stop sample of 0 sets the frame error. After STOP_BITS samples, do the completion step and go to IDLE in the same cycle; the rest of the stop bit is absorbed in IDLE.
- Completion step, one cycle after the final stop sample:
  - If o_valid_rx=0, or o_valid_rx=1 with i_ready_rx=1 in that cycle: load o_data_rx and both error flags, set o_valid_rx=1.
  - Otherwise: drop the frame, set o_overrun=1, keep the held word unchanged.
- Handshake: o_valid_rx clears on a cycle where o_valid_rx=1 and i_ready_rx=1 and no completion occurs. o_data_rx and the error flags hold until the next load.
- Overrun: cleared by i_clr_ovr. If i_clr_ovr and a new overrun coincide, set wins.
- i_enb_rx=0 in any non-IDLE state: abort to IDLE next cycle, no output, the holding register is untouched.
- Break (line held low): the frame completes with o_frame_err=1 and data 0. The receiver does not restart until the line has returned high once: IDLE waits for a 1 then a 0.
- Latency: o_valid_rx rises 3 i_clk cycles after the final stop-bit sample point (2 synchroniser stages plus the completion step).

Decomposition:
- Shared package pkg gains:
  - rx2_state enum {RX2_IDLE, RX2_START, RX2_DATA, RX2_PARITY, RX2_STOP}.
  - parity_mode_t enum.
  - Default constants for CLKS_PER_BIT, DATA_BITS and STOP_BITS.
- Sub-module uart_rx_sampler: contains the synchroniser, the 3-sample shift register and the majority output. Ports: i_clk, i_rst_n, i_line, o_sync, o_majority.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated):
- 8N1 frame 0xA5, i_ready_rx=1 -> o_data_rx=0xA5; o_valid_rx high for exactly 1 cycle, 3 cycles after the stop sample; both error flags 0.
- Even parity, 0x3C sent with parity bit 1 -> o_parity_err=1. Same frame with parity bit 0 -> o_parity_err=0. Odd mode with parity bit 1 -> o_parity_err=0.
- Stop bit driven 0 on 0x55 -> o_frame_err=1, o_data_rx=0x55. STOP_BITS=2 with only the second stop bit 0 -> o_frame_err=1.
- 4-cycle low glitch in IDLE -> no o_valid_rx; a following valid 0x12 frame is received correctly. A 1-cycle spike mid-data-bit is rejected by the majority vote.
- i_ready_rx=0; send 0x11 then 0x22 -> held word 0x11, o_overrun=1. i_clr_ovr pulse -> o_overrun=0. Assert i_ready_rx in the completion cycle of the second frame -> 0x22 loaded, no overrun.
- Assert i_rst_n low or drop i_enb_rx in the middle of data bits -> IDLE, all outputs 0 (reset) or held word unchanged (enable drop); the next frame 0xF0 is received cleanly.
